// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: multi-cycle word-addressed data memory,
// upstream stall control, branch resolution and the MEM/WB pipeline register.
module memory_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ip_ALU_result,
  input  logic [31:0] ip_memory_write_data,
  input  logic [4:0]  ip_dest_reg,
  input  logic [7:0]  ip_Add_result,
  input  logic        ip_zero,
  input  logic        ip_branch,
  input  logic        ip_MemtoReg,
  input  logic        ip_RegWrite,
  input  logic        ip_read_en,
  input  logic        ip_write_en,
  output logic        op_stall,
  output logic        op_PCSrc,
  output logic [7:0]  op_branch_target,
  output logic [31:0] op_read_data,
  output logic [31:0] op_ALU_result,
  output logic [4:0]  op_dest_reg,
  output logic        op_MemtoReg,
  output logic        op_RegWrite
);

  localparam int ADDR_W = $clog2(DEPTH);
  // First BUSY cycle already accounts for one cycle of latency beyond the IDLE cycle.
  localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              access, commit, bubble, stall;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem [DEPTH];

  logic [31:0]       read_data_p1;
  logic [31:0]       alu_result_p1;
  logic [4:0]        dest_reg_p1;
  logic              memtoreg_p1;
  logic              regwrite_p1;

  assign access = ip_read_en | ip_write_en;
  assign idx    = ip_ALU_result[ADDR_W+1:2];

  assign op_PCSrc         = ip_branch & ip_zero;
  assign op_branch_target = ip_Add_result;
  assign op_stall         = stall & ~reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && (MEM_LATENCY > 1)) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else begin
          commit = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- MEM/WB register (p1) ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      read_data_p1  <= '0;
      alu_result_p1 <= '0;
      dest_reg_p1   <= '0;
      memtoreg_p1   <= 1'b0;
      regwrite_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        read_data_p1  <= mem[idx];
        alu_result_p1 <= ip_ALU_result;
        dest_reg_p1   <= ip_dest_reg;
        memtoreg_p1   <= ip_MemtoReg;
        regwrite_p1   <= ip_RegWrite;
      end else if (bubble) begin
        memtoreg_p1 <= 1'b0;
        regwrite_p1 <= 1'b0;
      end
    end
  end

  // Store lands only on the commit cycle; a reset during the access drops it.
  always_ff @(posedge clock) begin
    if (!reset && commit && ip_write_en)
      mem[idx] <= ip_memory_write_data;
  end

  assign op_read_data  = read_data_p1;
  assign op_ALU_result = alu_result_p1;
  assign op_dest_reg   = dest_reg_p1;
  assign op_MemtoReg   = memtoreg_p1;
  assign op_RegWrite   = regwrite_p1;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: instance 0 uses latency 2, instance 1 latency 4, both checked
// against a word-array reference model of the data memory.
module tb_memory_stage;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] alu    [2];
  logic [31:0] wdata  [2];
  logic [4:0]  dest   [2];
  logic [7:0]  addres [2];
  logic        zero   [2];
  logic        branch [2];
  logic        m2r    [2];
  logic        rw     [2];
  logic        rd     [2];
  logic        wr     [2];

  logic        stall  [2];
  logic        pcsrc  [2];
  logic [7:0]  btgt   [2];
  logic [31:0] o_rd   [2];
  logic [31:0] o_alu  [2];
  logic [4:0]  o_dest [2];
  logic        o_m2r  [2];
  logic        o_rw   [2];

  memory_stage #(.DEPTH(DEPTH), .MEM_LATENCY(2)) dut_l2 (
    .clock(clk), .reset(reset),
    .ip_ALU_result(alu[0]), .ip_memory_write_data(wdata[0]), .ip_dest_reg(dest[0]),
    .ip_Add_result(addres[0]), .ip_zero(zero[0]), .ip_branch(branch[0]),
    .ip_MemtoReg(m2r[0]), .ip_RegWrite(rw[0]), .ip_read_en(rd[0]), .ip_write_en(wr[0]),
    .op_stall(stall[0]), .op_PCSrc(pcsrc[0]), .op_branch_target(btgt[0]),
    .op_read_data(o_rd[0]), .op_ALU_result(o_alu[0]), .op_dest_reg(o_dest[0]),
    .op_MemtoReg(o_m2r[0]), .op_RegWrite(o_rw[0]));

  memory_stage #(.DEPTH(DEPTH), .MEM_LATENCY(4)) dut_l4 (
    .clock(clk), .reset(reset),
    .ip_ALU_result(alu[1]), .ip_memory_write_data(wdata[1]), .ip_dest_reg(dest[1]),
    .ip_Add_result(addres[1]), .ip_zero(zero[1]), .ip_branch(branch[1]),
    .ip_MemtoReg(m2r[1]), .ip_RegWrite(rw[1]), .ip_read_en(rd[1]), .ip_write_en(wr[1]),
    .op_stall(stall[1]), .op_PCSrc(pcsrc[1]), .op_branch_target(btgt[1]),
    .op_read_data(o_rd[1]), .op_ALU_result(o_alu[1]), .op_dest_reg(o_dest[1]),
    .op_MemtoReg(o_m2r[1]), .op_RegWrite(o_rw[1]));

  // Reference model: memory contents per instance, with a flag for words ever written.
  logic [31:0] mdl [2][DEPTH];
  bit          vld [2][DEPTH];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic set_idle(input int d);
    alu[d] = '0; wdata[d] = '0; dest[d] = '0; addres[d] = '0;
    zero[d] = 1'b0; branch[d] = 1'b0; m2r[d] = 1'b0; rw[d] = 1'b0;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // One complete EX/MEM transaction held until it commits, checked against the model.
  task automatic do_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [4:0] dst, input logic mr, input logic rwr,
                           input logic r, input logic w, input string name);
    int lat, stalls, idx;
    bit done, known;
    logic [31:0] exp_rd;
    lat    = (d == 1) ? 4 : 2;
    idx    = int'((a >> 2) % DEPTH);
    known  = vld[d][idx];
    exp_rd = mdl[d][idx];
    stalls = 0;
    done   = 0;
    @(negedge clk);
    alu[d] = a; wdata[d] = wd; dest[d] = dst; m2r[d] = mr; rw[d] = rwr; rd[d] = r; wr[d] = w;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (stall[d] !== 1'b1) begin
        done = 1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      chk({name, " bubble RegWrite"}, {31'd0, o_rw[d]}, 32'd0);
      chk({name, " bubble MemtoReg"}, {31'd0, o_m2r[d]}, 32'd0);
      @(negedge clk);
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s: stall never released within 20 cycles", name);
    end else begin
      chk({name, " stall cycles"}, stalls, (r | w) ? lat - 1 : 0);
      @(posedge clk); #1;
      if (known) chk({name, " read_data"}, o_rd[d], exp_rd);
      chk({name, " ALU_result"}, o_alu[d], a);
      chk({name, " dest_reg"}, {27'd0, o_dest[d]}, {27'd0, dst});
      chk({name, " MemtoReg"}, {31'd0, o_m2r[d]}, {31'd0, mr});
      chk({name, " RegWrite"}, {31'd0, o_rw[d]}, {31'd0, rwr});
      if (w) begin
        mdl[d][idx] = wd;
        vld[d][idx] = 1;
      end
    end
    @(negedge clk);
    set_idle(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle(0);
    set_idle(1);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset stall", {31'd0, stall[d]}, 32'd0);
      chk("reset read_data", o_rd[d], 32'd0);
      chk("reset ALU_result", o_alu[d], 32'd0);
      chk("reset ctrl", {25'd0, o_dest[d], o_m2r[d], o_rw[d]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    do_access(0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "L2 store");
    do_access(0, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, "L2 load");
    chk("L2 load value", o_rd[0], 32'hDEADBEEF);
  endtask

  task automatic test_passthrough();
    do_access(0, 32'h1234, 32'h600DF00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "pt setup");
    do_access(0, 32'h1234, 32'hBAADBAAD, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, "pass-through");
    do_access(0, 32'h1234, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, "pt readback");
  endtask

  task automatic test_wrap();
    do_access(0, 32'h400, 32'hA5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "wrap store");
    do_access(0, 32'h000, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, "wrap load 0x000");
    chk("wrap value", o_rd[0], 32'hA5);
    do_access(0, 32'h403, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, "wrap load 0x403");
    chk("low bits value", o_rd[0], 32'hA5);
  endtask

  task automatic test_long_latency();
    do_access(1, 32'h80, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, "L4 prime");
    do_access(1, 32'h80, 32'hCAFE0001, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, "L4 store");
    do_access(1, 32'h80, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, "L4 load");
    do_access(1, 32'h80, 32'h12345678, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, "L4 rd+wr");
    do_access(1, 32'h80, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, "L4 after rd+wr");
  endtask

  task automatic test_branch();
    @(negedge clk);
    branch[0] = 1'b1; zero[0] = 1'b1; addres[0] = 8'h2C;
    #1;
    chk("branch taken", {31'd0, pcsrc[0]}, 32'd1);
    chk("branch target", {24'd0, btgt[0]}, 32'h2C);
    zero[0] = 1'b0;
    #1;
    chk("branch not taken", {31'd0, pcsrc[0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic b, z;
      logic [7:0] t;
      b = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      t = 8'($urandom);
      branch[1] = b; zero[1] = z; addres[1] = t;
      #1;
      chk("branch rand PCSrc", {31'd0, pcsrc[1]}, {31'd0, b & z});
      chk("branch rand target", {24'd0, btgt[1]}, {24'd0, t});
    end
    set_idle(0);
    set_idle(1);
  endtask

  task automatic test_reset_mid_access();
    do_access(1, 32'h40, 32'h11112222, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "pre-reset store");
    @(negedge clk);
    alu[1] = 32'h40; wdata[1] = 32'h99998888; wr[1] = 1'b1; rw[1] = 1'b1; dest[1] = 5'd9;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset forces stall low", {31'd0, stall[1]}, 32'd0);
    @(posedge clk); #1;
    chk("mid reset stall", {31'd0, stall[1]}, 32'd0);
    chk("mid reset outputs", o_rd[1] | o_alu[1] | {25'd0, o_dest[1], o_m2r[1], o_rw[1]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_idle(1);
    #1;
    chk("post reset idle stall", {31'd0, stall[1]}, 32'd0);
    do_access(1, 32'h40, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, "post-reset load");
    chk("store discarded", o_rd[1], 32'h11112222);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      int d, sel;
      logic [31:0] a;
      logic [7:0] ix;
      d  = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      a  = $urandom;
      ix = 8'($urandom_range(0, 7));
      a[9:2] = ix;
      do_access(d, a, $urandom, 5'($urandom), sel[0], 1'($urandom_range(0, 1)),
                sel[0], sel[1], "random");
    end
  endtask

  initial begin
    set_idle(0);
    set_idle(1);
    test_reset();
    test_store_load();
    test_passthrough();
    test_wrap();
    test_long_latency();
    test_branch();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
